// File: rtl/vc4poh_tx_if.sv
// Mapper/monitor-facing signal bundle for the VC-4 TX POH generator.
// b3_err_ins exists only when VC4POH_TX_B3ERR_EN is defined.
interface vc4poh_tx_if #(
    parameter int WIDTH  = 8,
    parameter int J1_LEN = 16
);
    logic                        txsof;
    logic                        en;
    logic [WIDTH-1:0]            dpohout;
    logic                        dpoh_vld;
    logic [WIDTH-1:0]            tug3bip8;
    logic                        bip_vld;
    logic [3:0]                  rei_bip8;
    logic                        rei_vld;
    logic                        rdi;
    logic [WIDTH-1:0]            c2_val;
    logic                        j1_wr;
    logic [$clog2(J1_LEN)-1:0]   j1_addr;
    logic [WIDTH-1:0]            j1_data;
`ifdef VC4POH_TX_B3ERR_EN
    logic                        b3_err_ins;
`endif

    modport master (
        output txsof, en, tug3bip8, bip_vld, rei_bip8, rei_vld, rdi, c2_val,
               j1_wr, j1_addr, j1_data,
`ifdef VC4POH_TX_B3ERR_EN
        output b3_err_ins,
`endif
        input  dpohout, dpoh_vld
    );

    modport slave (
        input  txsof, en, tug3bip8, bip_vld, rei_bip8, rei_vld, rdi, c2_val,
               j1_wr, j1_addr, j1_data,
`ifdef VC4POH_TX_B3ERR_EN
        input  b3_err_ins,
`endif
        output dpohout, dpoh_vld
    );
endinterface

// File: rtl/vc4poh_tx.sv
// VC-4 TX path overhead generator (J1..N1, B3, REI/RDI in G1, H4 multiframe); VC4POH_TX_B3ERR_EN adds a B3 error injector.
// One-cycle registered output per en strobe; no backpressure, the mapper paces bytes with en.
module vc4poh_tx #(
    parameter int WIDTH  = 8,
    parameter int J1_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    vc4poh_tx_if.slave bus
);
    localparam int AW = $clog2(J1_LEN);

    typedef enum logic [3:0] {
        ROW_J1   = 4'd0,
        ROW_B3   = 4'd1,
        ROW_C2   = 4'd2,
        ROW_G1   = 4'd3,
        ROW_F2   = 4'd4,
        ROW_H4   = 4'd5,
        ROW_F3   = 4'd6,
        ROW_K3   = 4'd7,
        ROW_N1   = 4'd8,
        ROW_DONE = 4'd9
    } row_e;

    row_e             row_q, row_d, row_eff;
    logic [AW-1:0]    j1_ptr_q, j1_ptr_d;
    logic [1:0]       mf_q, mf_d;
    logic [WIDTH-1:0] poh_acc_q, poh_acc_d;
    logic [WIDTH-1:0] pay_bip_q, pay_bip_d;
    logic [WIDTH-1:0] b3_reg_q, b3_reg_d;
    logic [WIDTH-1:0] dpohout_q, dpohout_d;
    logic             dpoh_vld_q;
    logic [3:0]       rei_lat_q, rei_lat_d;
    logic             rdi_lat_q, rdi_lat_d;
    logic             rei_vld_d_q;
    logic [WIDTH-1:0] ram_q [J1_LEN];
    logic [WIDTH-1:0] slot_byte;
    logic             slot_live;
    logic             g1_emit;
    logic             b3_flip;

    // A coincident txsof restarts the frame before en is served.
    assign row_eff   = bus.txsof ? ROW_J1 : row_q;
    assign slot_live = bus.en && (row_eff != ROW_DONE);
    assign g1_emit   = slot_live && (row_eff == ROW_G1);

`ifdef VC4POH_TX_B3ERR_EN
    logic b3_arm_q, b3_arm_d;
    logic b3_emit;

    assign b3_emit = slot_live && (row_eff == ROW_B3);
    assign b3_flip = b3_arm_q;
    // A pulse during the B3 slot itself arms for the following frame.
    assign b3_arm_d = (b3_arm_q & ~b3_emit) | bus.b3_err_ins;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) b3_arm_q <= 1'b0;
        else      b3_arm_q <= b3_arm_d;
    end
`else
    assign b3_flip = 1'b0;
`endif

    always_comb begin
        slot_byte = {WIDTH{1'b0}};
        case (row_eff)
            ROW_J1:  slot_byte = ram_q[j1_ptr_q];
            ROW_B3:  slot_byte = b3_reg_q ^ {{(WIDTH-1){1'b0}}, b3_flip};
            ROW_C2:  slot_byte = bus.c2_val;
            ROW_G1:  slot_byte = {rei_lat_q, rdi_lat_q, {(WIDTH-5){1'b0}}};
            ROW_H4:  slot_byte = {{(WIDTH-2){1'b1}}, mf_q};
            default: slot_byte = {WIDTH{1'b0}};
        endcase
    end

    always_comb begin
        row_d     = row_q;
        j1_ptr_d  = j1_ptr_q;
        mf_d      = mf_q;
        poh_acc_d = poh_acc_q;
        b3_reg_d  = b3_reg_q;
        rdi_lat_d = rdi_lat_q;
        dpohout_d = dpohout_q;
        pay_bip_d = bus.bip_vld ? bus.tug3bip8 : pay_bip_q;

        if (bus.txsof) begin
            row_d     = ROW_J1;
            b3_reg_d  = poh_acc_q ^ pay_bip_q;
            poh_acc_d = {WIDTH{1'b0}};
            mf_d      = mf_q + 2'd1;
            rdi_lat_d = bus.rdi;
        end

        if (bus.en) begin
            if (row_eff == ROW_DONE) begin
                dpohout_d = {WIDTH{1'b0}};
            end else begin
                dpohout_d = slot_byte;
                poh_acc_d = (bus.txsof ? {WIDTH{1'b0}} : poh_acc_q) ^ slot_byte;
                row_d     = row_e'(row_eff + 4'd1);
                if (row_eff == ROW_J1)
                    j1_ptr_d = j1_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
        end

        // A fresh REI edge wins over the clear, so G1 still carries the old count.
        rei_lat_d = g1_emit ? 4'd0 : rei_lat_q;
        if (bus.rei_vld && !rei_vld_d_q)
            rei_lat_d = (bus.rei_bip8 > 4'd8) ? 4'd0 : bus.rei_bip8;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q       <= ROW_J1;
            j1_ptr_q    <= '0;
            mf_q        <= 2'd0;
            poh_acc_q   <= '0;
            pay_bip_q   <= '0;
            b3_reg_q    <= '0;
            dpohout_q   <= '0;
            dpoh_vld_q  <= 1'b0;
            rei_lat_q   <= 4'd0;
            rdi_lat_q   <= 1'b0;
            rei_vld_d_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            j1_ptr_q    <= j1_ptr_d;
            mf_q        <= mf_d;
            poh_acc_q   <= poh_acc_d;
            pay_bip_q   <= pay_bip_d;
            b3_reg_q    <= b3_reg_d;
            dpohout_q   <= dpohout_d;
            dpoh_vld_q  <= bus.en;
            rei_lat_q   <= rei_lat_d;
            rdi_lat_q   <= rdi_lat_d;
            rei_vld_d_q <= bus.rei_vld;
        end
    end

    // Read uses the pre-write contents when a write hits the same address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < J1_LEN; i++) ram_q[i] <= '0;
        end else if (bus.j1_wr) begin
            ram_q[bus.j1_addr] <= bus.j1_data;
        end
    end

    assign bus.dpohout  = dpohout_q;
    assign bus.dpoh_vld = dpoh_vld_q;
endmodule

// File: tb/tb_vc4poh_tx.sv
// Bench for vc4poh_tx: vector table, hand-written corner sequences and randomized traffic against a frame-level model.
module tb_vc4poh_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vc4poh_tx_if #(.WIDTH(8), .J1_LEN(16)) bus ();
    vc4poh_tx #(.WIDTH(8), .J1_LEN(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, updated once per clock from the applied inputs.
    int       m_row, m_ptr, m_mf;
    bit [7:0] m_ram [16];
    bit [7:0] m_acc, m_pay, m_b3, m_dat;
    bit [3:0] m_rei;
    bit       m_rdi, m_prev, m_vld, m_arm;

    typedef struct {
        bit       sof;
        bit       en;
        bit       vld;
        bit [7:0] dat;
    } vec_t;
    vec_t tv[$];

    bit [7:0] b3v, g1v, exp8;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_ptr = 0; m_mf = 0;
        m_acc = 0; m_pay = 0; m_b3 = 0; m_dat = 0;
        m_rei = 0; m_rdi = 0; m_prev = 0; m_vld = 0; m_arm = 0;
        foreach (m_ram[i]) m_ram[i] = 8'h00;
    endtask

    task automatic model_step();
        bit [7:0] byt;
        bit       g1;
        g1 = 0;
        byt = 0;
        if (bus.txsof) begin
            m_b3  = m_acc ^ m_pay;
            m_acc = 0;
            m_mf  = (m_mf + 1) % 4;
            m_rdi = bus.rdi;
            m_row = 0;
        end
        m_vld = bus.en;
        if (bus.en) begin
            if (m_row >= 9) begin
                m_dat = 8'h00;
            end else begin
                case (m_row)
                    0: begin byt = m_ram[m_ptr]; m_ptr = (m_ptr + 1) % 16; end
                    1: begin byt = m_b3 ^ {7'b0, m_arm}; m_arm = 0; end
                    2: byt = bus.c2_val;
                    3: begin byt = {m_rei, m_rdi, 3'b000}; g1 = 1; end
                    5: byt = 8'hFC | 8'(m_mf);
                    default: byt = 8'h00;
                endcase
                m_acc = m_acc ^ byt;
                m_dat = byt;
                m_row++;
            end
        end
        if (g1) m_rei = 0;
        if (bus.rei_vld && !m_prev) m_rei = (bus.rei_bip8 > 8) ? 4'd0 : bus.rei_bip8;
        m_prev = bus.rei_vld;
        if (bus.bip_vld) m_pay = bus.tug3bip8;
        if (bus.j1_wr) m_ram[bus.j1_addr] = bus.j1_data;
`ifdef VC4POH_TX_B3ERR_EN
        if (bus.b3_err_ins) m_arm = 1;
`endif
    endtask

    task automatic clear_pulses();
        bus.txsof = 0; bus.en = 0; bus.bip_vld = 0; bus.j1_wr = 0;
`ifdef VC4POH_TX_B3ERR_EN
        bus.b3_err_ins = 0;
`endif
    endtask

    // Advance one clock and compare the DUT against the model.
    task automatic step(input string nm);
        model_step();
        @(posedge clk);
        #1;
        chk({nm, " vld"}, bus.dpoh_vld, m_vld);
        chk({nm, " dat"}, bus.dpohout, m_dat);
        clear_pulses();
    endtask

    task automatic frame9(input bit drop_rdi, input bit edge_g1, output bit [7:0] b3, output bit [7:0] g1);
        b3 = 0;
        g1 = 0;
        bus.txsof = 1;
        step("sof");
        if (drop_rdi) bus.rdi = 0;
        for (int r = 0; r < 9; r++) begin
            bus.en = 1;
            if (edge_g1 && r == 3) begin bus.rei_bip8 = 4'd3; bus.rei_vld = 1; end
            step($sformatf("row%0d", r));
            if (r == 1) b3 = bus.dpohout;
            if (r == 3) g1 = bus.dpohout;
        end
        bus.rei_vld = 0;
    endtask

    initial begin
        bus.txsof = 0; bus.en = 0; bus.tug3bip8 = 0; bus.bip_vld = 0;
        bus.rei_bip8 = 0; bus.rei_vld = 0; bus.rdi = 0; bus.c2_val = 8'h02;
        bus.j1_wr = 0; bus.j1_addr = 0; bus.j1_data = 0;
`ifdef VC4POH_TX_B3ERR_EN
        bus.b3_err_ins = 0;
`endif
        model_reset();
        #2;
        chk("reset dpohout", bus.dpohout, 0);
        chk("reset dpoh_vld", bus.dpoh_vld, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;

        // Two frames from reset: plain frame, then sof+en coincident with three surplus en.
        tv.push_back('{1, 0, 0, 8'h00});
        tv.push_back('{0, 1, 1, 8'h00});
        tv.push_back('{0, 1, 1, 8'h00});
        tv.push_back('{0, 1, 1, 8'h02});
        tv.push_back('{0, 1, 1, 8'h00});
        tv.push_back('{0, 1, 1, 8'h00});
        tv.push_back('{0, 1, 1, 8'hFD});
        for (int i = 0; i < 3; i++) tv.push_back('{0, 1, 1, 8'h00});
        tv.push_back('{0, 0, 0, 8'h00});
        tv.push_back('{1, 1, 1, 8'h00});
        tv.push_back('{0, 1, 1, 8'hFF});
        tv.push_back('{0, 1, 1, 8'h02});
        tv.push_back('{0, 1, 1, 8'h00});
        tv.push_back('{0, 1, 1, 8'h00});
        tv.push_back('{0, 1, 1, 8'hFE});
        for (int i = 0; i < 6; i++) tv.push_back('{0, 1, 1, 8'h00});
        tv.push_back('{0, 0, 0, 8'h00});
        foreach (tv[i]) begin
            bus.txsof = tv[i].sof;
            bus.en    = tv[i].en;
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d vld", i), bus.dpoh_vld, tv[i].vld);
            chk($sformatf("vec%0d dat", i), bus.dpohout, tv[i].dat);
            clear_pulses();
        end

        // REI latch and saturation.
        bus.rei_bip8 = 4'd5; bus.rei_vld = 1; step("rei5");
        bus.rei_vld = 0; step("idle");
        frame9(0, 0, b3v, g1v); chk("g1 rei5", g1v, 8'h50);
        frame9(0, 0, b3v, g1v); chk("g1 rei cleared", g1v, 8'h00);
        bus.rei_bip8 = 4'd12; bus.rei_vld = 1; step("rei12");
        bus.rei_vld = 0; step("idle");
        frame9(0, 0, b3v, g1v); chk("g1 rei12", g1v, 8'h00);

        // RDI held for the frame it was sampled in.
        bus.rdi = 1;
        frame9(0, 0, b3v, g1v); chk("g1 rdi", g1v, 8'h08);
        bus.rdi = 1;
        frame9(1, 0, b3v, g1v); chk("g1 rdi dropped mid", g1v, 8'h08);
        frame9(0, 0, b3v, g1v); chk("g1 rdi gone", g1v, 8'h00);

        // REI edge coincident with G1 emission.
        frame9(0, 1, b3v, g1v); chk("g1 coincident old", g1v, 8'h00);
        frame9(0, 0, b3v, g1v); chk("g1 coincident new", g1v, 8'h30);

        // Payload BIP folded into the next B3, last strobe wins.
        bus.tug3bip8 = 8'h11; bus.bip_vld = 1; step("bip1");
        bus.tug3bip8 = 8'h5A; bus.bip_vld = 1; step("bip2");
        exp8 = m_acc ^ 8'h5A;
        frame9(0, 0, b3v, g1v); chk("b3 with payload", b3v, exp8);

`ifdef VC4POH_TX_B3ERR_EN
        bus.b3_err_ins = 1; step("errins");
        exp8 = m_acc ^ m_pay ^ 8'h01;
        frame9(0, 0, b3v, g1v); chk("b3 corrupted", b3v, exp8);
        exp8 = m_acc ^ m_pay;
        frame9(0, 0, b3v, g1v); chk("b3 recovered", b3v, exp8);
`endif

        // Asynchronous reset mid-frame, right after a non-zero C2.
        bus.c2_val = 8'hA5;
        bus.txsof = 1; step("sof");
        for (int r = 0; r < 3; r++) begin bus.en = 1; step("pre-rst"); end
        rst = 0;
        #1;
        chk("async rst dpohout", bus.dpohout, 0);
        chk("async rst dpoh_vld", bus.dpoh_vld, 0);
        model_reset();
        #2;
        rst = 1;
        step("post-rst");

        // J1 trace: load, read 17 frames (wrap), hold, write/read collision.
        for (int a = 0; a < 16; a++) begin
            bus.j1_wr = 1; bus.j1_addr = 4'(a);
            bus.j1_data = (a == 0) ? 8'h80 : 8'(8'h40 + a);
            step("j1wr");
        end
        for (int f = 0; f < 17; f++) begin
            bus.txsof = 1; step("j1sof");
            bus.en = 1;
            if (f == 16) begin bus.j1_wr = 1; bus.j1_addr = 4'd0; bus.j1_data = 8'h99; end
            step("j1rd");
            chk($sformatf("j1 frame%0d", f), bus.dpohout, (f % 16 == 0) ? 8'h80 : 8'(8'h40 + f));
            if (f == 0) begin
                step("hold");
                chk("j1 hold dat", bus.dpohout, 8'h80);
                chk("j1 hold vld", bus.dpoh_vld, 0);
            end
            for (int r = 1; r < 9; r++) begin bus.en = 1; step("j1row"); end
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.txsof    = ($urandom_range(0, 15) == 0);
            bus.en       = ($urandom_range(0, 2) != 0);
            bus.c2_val   = 8'($urandom);
            bus.bip_vld  = ($urandom_range(0, 9) == 0);
            bus.tug3bip8 = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bus.rei_vld = ~bus.rei_vld;
            bus.rei_bip8 = 4'($urandom);
            if ($urandom_range(0, 19) == 0) bus.rdi = ~bus.rdi;
            bus.j1_wr    = ($urandom_range(0, 4) == 0);
            bus.j1_addr  = 4'($urandom);
            bus.j1_data  = 8'($urandom);
`ifdef VC4POH_TX_B3ERR_EN
            bus.b3_err_ins = ($urandom_range(0, 29) == 0);
`endif
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
